// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one uart_tx between NUM_REQ byte-stream requesters.
// A requester is locked from its first byte until it hands over a byte marked
// last, so packets never interleave. One byte is buffered towards uart_tx at a
// time. A locked requester that goes quiet for TIMEOUT_CYCLES cycles with an
// empty buffer is forcibly released and the sticky timeout_flag is raised.
module uart_tx_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [NUM_REQ*8-1:0]   req_data,
  input  logic [NUM_REQ-1:0]     req_last,
  output logic [NUM_REQ-1:0]     req_ready,
  output logic [7:0]             tx_data,
  output logic                   tx_valid,
  input  logic                   tx_ready,
  output logic [2:0]             grant_id,
  output logic                   busy,
  output logic                   timeout_flag,
  input  logic                   timeout_clr
);

  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t          state_r;
  logic            buf_valid_r;
  logic [7:0]      buf_data_r;
  logic            buf_last_r;
  logic [2:0]      rr_ptr_r;
  logic [CW-1:0]   to_cnt_r;

  logic            pick_found_s;
  logic [2:0]      pick_idx_s;
  logic [3:0]      cand_s;
  logic            hit_s;
  logic            g_valid_s;
  logic [7:0]      g_data_s;
  logic            g_last_s;
  logic            sel_s;
  logic            timeout_hit_s;

  assign tx_valid = buf_valid_r;
  assign tx_data  = buf_data_r;
  assign busy     = (state_r == LOCKED);

  // Round-robin pick: first valid requester starting at rr_ptr+1, wrapping.
  always_comb begin
    pick_found_s = 1'b0;
    pick_idx_s   = 3'd0;
    cand_s       = 4'd0;
    hit_s        = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand_s = {1'b0, rr_ptr_r} + 4'(k);
      if (cand_s >= 4'(NUM_REQ)) begin
        cand_s = cand_s - 4'(NUM_REQ);
      end else begin
        cand_s = cand_s;
      end
      for (int i = 0; i < NUM_REQ; i++) begin
        hit_s        = !pick_found_s && req_valid[i] && (cand_s == 4'(i));
        pick_idx_s   = hit_s ? 3'(i) : pick_idx_s;
        pick_found_s = pick_found_s | hit_s;
      end
    end
  end

  // Granted-requester mux and per-requester ready (only the locked one, only with room).
  always_comb begin
    g_valid_s = 1'b0;
    g_data_s  = 8'd0;
    g_last_s  = 1'b0;
    sel_s     = 1'b0;
    req_ready = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      sel_s        = (grant_id == 3'(i));
      g_valid_s    = g_valid_s | (sel_s & req_valid[i]);
      g_data_s     = g_data_s | ({8{sel_s}} & req_data[8*i +: 8]);
      g_last_s     = g_last_s | (sel_s & req_last[i]);
      req_ready[i] = rst_n && (state_r == LOCKED) && sel_s && !buf_valid_r;
    end
  end

  // Forced release fires only with an empty buffer and a silent locked requester.
  assign timeout_hit_s = (state_r == LOCKED) && !buf_valid_r && !g_valid_s &&
                         (to_cnt_r == TO_LAST);

  // Lock FSM, byte buffer, round-robin pointer, idle counter and sticky flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      buf_valid_r  <= 1'b0;
      buf_data_r   <= 8'd0;
      buf_last_r   <= 1'b0;
      grant_id     <= 3'd0;
      rr_ptr_r     <= 3'(NUM_REQ - 1);
      to_cnt_r     <= '0;
      timeout_flag <= 1'b0;
    end else begin
      if (timeout_hit_s) begin
        timeout_flag <= 1'b1;
      end else if (timeout_clr) begin
        timeout_flag <= 1'b0;
      end

      case (state_r)
        IDLE: begin
          if (pick_found_s) begin
            grant_id <= pick_idx_s;
            to_cnt_r <= '0;
            state_r  <= LOCKED;
          end
        end
        LOCKED: begin
          if (buf_valid_r) begin
            // Waiting on uart_tx is unbounded; the idle counter holds here.
            if (tx_ready) begin
              buf_valid_r <= 1'b0;
              if (buf_last_r) begin
                rr_ptr_r <= grant_id;
                state_r  <= IDLE;
              end
            end
          end else if (g_valid_s) begin
            buf_valid_r <= 1'b1;
            buf_data_r  <= g_data_s;
            buf_last_r  <= g_last_s;
            to_cnt_r    <= '0;
          end else if (to_cnt_r == TO_LAST) begin
            rr_ptr_r <= grant_id;
            state_r  <= IDLE;
          end else begin
            to_cnt_r <= to_cnt_r + CW'(1);
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
- REQ-001: Parameter NUM_REQ, default 4, is the number of requesters sharing one uart_tx (legal range 2..8).
- REQ-002: Parameter TIMEOUT_CYCLES, default 1_000_000, is the idle-cycle limit inside a locked packet before forced release.
- REQ-003: clk  input  1  system clock, 100 MHz; single clock domain.
- REQ-004: rst_n  input  1  reset, synchronous, active-low.
- REQ-005: req_valid  input  NUM_REQ  per-requester byte valid.
- REQ-006: req_data  input  NUM_REQ*8  per-requester byte; requester i occupies bits [8i+7:8i].
- REQ-007: req_last  input  NUM_REQ  per-requester end-of-packet marker, qualified by req_valid.
- REQ-008: req_ready  output  NUM_REQ  per-requester byte accept.
- REQ-009: tx_data  output  8  byte to uart_tx.
- REQ-010: tx_valid  output  1  byte valid to uart_tx.
- REQ-011: tx_ready  input  1  uart_tx idle and able to accept.
- REQ-012: grant_id  output  3  index of the locked requester, meaningful when busy=1.
- REQ-013: busy  output  1  high while a requester holds the lock.
- REQ-014: timeout_flag  output  1  sticky: a forced release has occurred.
- REQ-015: timeout_clr  input  1  clears timeout_flag.

Function
- REQ-016: The block SHALL be an FSM with states IDLE and LOCKED plus a one-entry byte buffer (buf_valid, buf_data, buf_last).
- REQ-017: In IDLE with any req_valid high, the block SHALL pick the first requester with req_valid set, searching round-robin from rr_ptr+1 modulo NUM_REQ, register it to grant_id, and enter LOCKED on the next edge; arbitration takes exactly 1 cycle.
- REQ-018: req_ready[i] SHALL be combinational and equal (state==LOCKED && grant_id==i && !buf_valid); all other bits SHALL be 0.
- REQ-019: A byte SHALL be accepted when req_valid[g] && req_ready[g]; on that edge buf_valid=1, buf_data=req_data[g], and buf_last=req_last[g].
- REQ-020: tx_valid SHALL equal buf_valid, and tx_data SHALL equal buf_data; the buffer SHALL clear on the edge where tx_valid && tx_ready.
- REQ-021: Latency SHALL be: req_valid at cycle 0 in IDLE -> busy and req_ready at cycle 1 -> tx_valid at cycle 2.
- REQ-022: After a handshake, req_ready SHALL stay low that cycle; the next accept is no earlier than the following cycle, so at most one byte is in flight.
- REQ-023: On the tx handshake of a byte with buf_last=1, the block SHALL set rr_ptr=grant_id and return to IDLE on the same edge; re-arbitration SHALL begin the following cycle.
- REQ-024: Requests from non-granted requesters SHALL be ignored while LOCKED; no preemption.
- REQ-025: A timeout counter SHALL count cycles in LOCKED with buf_valid=0 and req_valid[g]=0, reset to 0 on every accept and on entering LOCKED.
- REQ-026: When the timeout counter reaches TIMEOUT_CYCLES-1, the block SHALL, on the next edge, return to IDLE, set rr_ptr=grant_id, and set timeout_flag.
- REQ-027: A timeout SHALL never occur while buf_valid=1; waiting on tx_ready is unbounded.
- REQ-028: timeout_clr SHALL clear timeout_flag; if a timeout and timeout_clr coincide on the same edge, set wins.
- REQ-029: busy SHALL equal (state==LOCKED), and grant_id SHALL hold its value in IDLE.
- REQ-030: If req_last is high on a byte whose req_valid is low, req_last SHALL have no effect.

Reset
- REQ-031: On a clk edge with rst_n=0, the block SHALL enter IDLE with buf_valid=0, tx_valid=0, tx_data=0, grant_id=0, rr_ptr=NUM_REQ-1 (so requester 0 has first priority), timeout counter=0, and timeout_flag=0.
- REQ-032: Reset asserted mid-packet SHALL drop tx_valid on the next edge and discard the buffered byte; req_ready SHALL be all-zero while rst_n=0.

Verification
- REQ-033: Single packet: req 1 sends 0x41, 0x42(last) with tx_ready=1 -> tx_data sequence 0x41, 0x42; busy falls on the 0x42 handshake; grant_id=1.
- REQ-034: Round-robin: reqs 0, 2, and 3 all valid with 1-byte packets from reset -> grant order 0, 2, 3, 0.
- REQ-035: Lock: req 0 holds a 3-byte packet while req 1 is valid throughout -> req_ready[1]=0 until req 0's last byte is handshaken; req 1 is granted one cycle later.
- REQ-036: Backpressure: tx_ready held low for 50 cycles with a byte buffered -> tx_valid and tx_data stable, no timeout, and req_ready[g]=0 for all 50 cycles.
- REQ-037: Timeout (TIMEOUT_CYCLES=16): req 2 sends one non-last byte then drops valid -> IDLE 16 cycles after the buffer drains; timeout_flag=1; timeout_clr clears it.
- REQ-038: Reset mid-packet: rst_n=0 for 1 cycle while buf_valid=1 -> tx_valid=0 next cycle, busy=0, and first grant afterward goes to requester 0 if valid.
